// File: rtl/maf_sign_prep_pkg.sv
// Shared definitions for the multiply-add sign-path front end: default widths,
// bias and shift saturation, plus the stage-1 payload layout.
package maf_pkg;

  localparam int unsigned EXP_W     = 8;
  localparam int unsigned BIAS      = 127;
  localparam int unsigned SHIFT_SAT = 74;
  localparam int unsigned EXP_EXT_W = EXP_W + 2;

  typedef struct packed {
    logic                        sign_prod;
    logic                        eff_sub;
    logic                        sign_c;
    logic                        prod_zero;
    logic signed [EXP_EXT_W-1:0] exp_ab;
    logic        [EXP_W-1:0]     exp_c;
  } s1_payload_t;

endpackage : maf_pkg

// File: rtl/maf_sign_prep_exp_cmp.sv
// Combinational exponent comparison for stage 2: signed compare of the product
// exponent against the addend exponent, saturated absolute difference and max.
module maf_exp_cmp #(
  parameter int unsigned EXP_W     = maf_pkg::EXP_W,
  parameter int unsigned SHIFT_SAT = maf_pkg::SHIFT_SAT
) (
  input  logic signed [EXP_W+1:0] exp_ab,
  input  logic        [EXP_W-1:0] exp_c,
  input  logic                    prod_zero,
  output logic                    comp_exp,
  output logic        [EXP_W+1:0] exp_diff,
  output logic        [EXP_W+1:0] exp_max
);

  localparam int unsigned EXT_W = EXP_W + 2;
  localparam logic [EXT_W-1:0] SAT_VAL = EXT_W'(SHIFT_SAT);

  logic signed [EXT_W-1:0] c_ext;
  logic signed [EXT_W-1:0] diff;
  logic        [EXT_W-1:0] mag;
  logic                    ab_gt;

  // Both operands fit in EXT_W-1 magnitude bits, so the subtraction cannot wrap.
  assign c_ext = $signed({2'b00, exp_c});
  assign diff  = exp_ab - c_ext;
  assign ab_gt = exp_ab > c_ext;
  assign mag   = ab_gt ? diff : -diff;

  always_comb begin
    comp_exp = 1'b0;
    exp_diff = SAT_VAL;
    exp_max  = c_ext;
    if (!prod_zero) begin
      comp_exp = ab_gt;
      exp_diff = (mag > SAT_VAL) ? SAT_VAL : mag;
      exp_max  = ab_gt ? exp_ab : c_ext;
    end
  end

endmodule : maf_exp_cmp

// File: rtl/maf_sign_prep.sv
// Two-stage valid/ready front end of the multiply-add sign path.
// Optional MAF_SIGN_PREP_STATS_EN adds eff_sub_cnt, a wrapping count of effective subtractions.
module maf_sign_prep #(
  parameter int unsigned EXP_W     = maf_pkg::EXP_W,
  parameter int unsigned BIAS      = maf_pkg::BIAS,
  parameter int unsigned SHIFT_SAT = maf_pkg::SHIFT_SAT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign_a,
  input  logic             sign_b,
  input  logic             sign_c,
  input  logic [EXP_W-1:0] exp_a,
  input  logic [EXP_W-1:0] exp_b,
  input  logic [EXP_W-1:0] exp_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eff_sub,
  output logic             comp_exp,
  output logic             sign_prod,
  output logic             sign_c_q,
  output logic             prod_zero,
  output logic [EXP_W+1:0] exp_diff,
`ifdef MAF_SIGN_PREP_STATS_EN
  output logic [EXP_W+1:0] exp_max,
  output logic [15:0]      eff_sub_cnt
`else
  output logic [EXP_W+1:0] exp_max
`endif
);

  import maf_pkg::*;

  localparam int unsigned EXT_W = EXP_W + 2;

  logic        s1_v;
  logic        s2_v;
  logic        s1_adv;
  logic        s1_load;
  logic        s2_load;
  s1_payload_t s1_d;
  s1_payload_t s1_q;

  logic             cmp_comp;
  logic [EXT_W-1:0] cmp_diff;
  logic [EXT_W-1:0] cmp_max;

  assign s1_adv    = !s2_v || out_ready;
  assign in_ready  = !s1_v || s1_adv;
  assign s1_load   = in_valid && in_ready;
  assign s2_load   = s1_v && s1_adv;
  assign out_valid = s2_v;

  always_comb begin
    s1_d           = '0;
    s1_d.sign_prod = sign_a ^ sign_b;
    s1_d.eff_sub   = sign_a ^ sign_b ^ sign_c;
    s1_d.sign_c    = sign_c;
    s1_d.prod_zero = (exp_a == '0) || (exp_b == '0);
    s1_d.exp_ab    = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b})
                     - $signed(EXT_W'(BIAS));
    s1_d.exp_c     = exp_c;
  end

  // Valid flags: a stage refills in the same cycle it drains, so no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      if (s1_load)     s1_v <= 1'b1;
      else if (s1_adv) s1_v <= 1'b0;
      if (s2_load)        s2_v <= 1'b1;
      else if (out_ready) s2_v <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s1_q <= '0;
    else if (s1_load) s1_q <= s1_d;
  end

  maf_exp_cmp #(
    .EXP_W     (EXP_W),
    .SHIFT_SAT (SHIFT_SAT)
  ) u_exp_cmp (
    .exp_ab    (s1_q.exp_ab),
    .exp_c     (s1_q.exp_c),
    .prod_zero (s1_q.prod_zero),
    .comp_exp  (cmp_comp),
    .exp_diff  (cmp_diff),
    .exp_max   (cmp_max)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eff_sub   <= 1'b0;
      comp_exp  <= 1'b0;
      sign_prod <= 1'b0;
      sign_c_q  <= 1'b0;
      prod_zero <= 1'b0;
      exp_diff  <= '0;
      exp_max   <= '0;
    end else if (s2_load) begin
      eff_sub   <= s1_q.eff_sub;
      comp_exp  <= cmp_comp;
      sign_prod <= s1_q.sign_prod;
      sign_c_q  <= s1_q.sign_c;
      prod_zero <= s1_q.prod_zero;
      exp_diff  <= cmp_diff;
      exp_max   <= cmp_max;
    end
  end

`ifdef MAF_SIGN_PREP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) eff_sub_cnt <= '0;
    else if (s2_v && out_ready && eff_sub) eff_sub_cnt <= eff_sub_cnt + 16'd1;
  end
`endif

endmodule : maf_sign_prep

// File: tb/tb_maf_sign_prep.sv
// Randomized self-checking bench for maf_sign_prep against a queue-based reference model.
module tb_maf_sign_prep;

  localparam int EXP_W = 8;
  localparam int BIAS  = 127;
  localparam int SAT   = 74;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             sign_a = 1'b0, sign_b = 1'b0, sign_c = 1'b0;
  logic [EXP_W-1:0] exp_a = '0, exp_b = '0, exp_c = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             eff_sub, comp_exp, sign_prod, sign_c_q, prod_zero;
  logic [EXP_W+1:0] exp_diff, exp_max;
`ifdef MAF_SIGN_PREP_STATS_EN
  logic [15:0]      eff_sub_cnt;
  logic [15:0]      model_cnt = '0;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] prev_out;
  bit          prev_stall = 0;

  always #5 clk = ~clk;

  maf_sign_prep #(
    .EXP_W     (EXP_W),
    .BIAS      (BIAS),
    .SHIFT_SAT (SAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_a    (sign_a),
    .sign_b    (sign_b),
    .sign_c    (sign_c),
    .exp_a     (exp_a),
    .exp_b     (exp_b),
    .exp_c     (exp_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .eff_sub   (eff_sub),
    .comp_exp  (comp_exp),
    .sign_prod (sign_prod),
    .sign_c_q  (sign_c_q),
    .prod_zero (prod_zero),
    .exp_diff  (exp_diff),
`ifdef MAF_SIGN_PREP_STATS_EN
    .exp_max   (exp_max),
    .eff_sub_cnt (eff_sub_cnt)
`else
    .exp_max   (exp_max)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, want, $time);
    end
  endtask

  // Packed result: {eff_sub, comp_exp, sign_prod, sign_c, prod_zero, exp_diff[9:0], exp_max[9:0]}
  function automatic logic [31:0] ref_out(bit sa, bit sb, bit sc, int ea, int eb, int ec);
    int ab, d, mx, dv;
    bit pz, comp;
    ab   = ea + eb - BIAS;
    pz   = (ea == 0) || (eb == 0);
    d    = (ab > ec) ? ab - ec : ec - ab;
    comp = !pz && (ab > ec);
    dv   = pz ? SAT : ((d > SAT) ? SAT : d);
    mx   = pz ? ec : ((ab > ec) ? ab : ec);
    return {7'd0, sa ^ sb ^ sc, comp, sa ^ sb, sc, pz, 10'(dv), 10'(mx)};
  endfunction

  function automatic logic [31:0] dut_out();
    return {7'd0, eff_sub, comp_exp, sign_prod, sign_c_q, prod_zero, exp_diff, exp_max};
  endfunction

  // One clock cycle: drive at the falling edge, sample 1 ns later, predict the rising edge.
  task automatic step(input bit iv, input bit sa, input bit sb, input bit sc,
                      input int ea, input int eb, input int ec, input bit ordy,
                      output bit ov);
    logic [31:0] cur;
    @(negedge clk);
    in_valid  = iv;
    sign_a    = sa;
    sign_b    = sb;
    sign_c    = sc;
    exp_a     = EXP_W'(ea);
    exp_b     = EXP_W'(eb);
    exp_c     = EXP_W'(ec);
    out_ready = ordy;
    #1;
    ov  = out_valid;
    cur = dut_out();
    check("in_ready", 32'(in_ready), 32'((exp_q.size() < 2) || ordy));
`ifdef MAF_SIGN_PREP_STATS_EN
    check("eff_sub_cnt", 32'(eff_sub_cnt), 32'(model_cnt));
`endif
    if (prev_stall) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_hold", cur, prev_out);
    end
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        check("result", cur, exp_q[0]);
        if (ordy) begin
`ifdef MAF_SIGN_PREP_STATS_EN
          if (exp_q[0][24]) model_cnt = model_cnt + 16'd1;
`endif
          void'(exp_q.pop_front());
        end
      end
    end
    prev_stall = out_valid && !ordy;
    prev_out   = cur;
    if (iv && in_ready) exp_q.push_back(ref_out(sa, sb, sc, ea, eb, ec));
  endtask

  task automatic idle(input int n);
    bit ov;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 1, ov);
  endtask

  task automatic drain();
    int budget;
    budget = 50;
    while (exp_q.size() != 0 && budget > 0) begin
      idle(1);
      budget--;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic directed(input string tag, input bit sa, input bit sb, input bit sc,
                          input int ea, input int eb, input int ec);
    bit ov;
    step(1, sa, sb, sc, ea, eb, ec, 1, ov);
    step(0, 0, 0, 0, 0, 0, 0, 1, ov);
    check({tag, "_lat1"}, 32'(ov), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 1, ov);
    check({tag, "_lat2"}, 32'(ov), 32'd1);
    drain();
  endtask

  initial begin
    bit ov;
    int ea, eb, ec;
    int seen;

    // Reset held with a pending operand set
    in_valid = 1'b1;
    exp_a = 8'd130; exp_b = 8'd127; exp_c = 8'd128;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_outputs", dut_out(), 32'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid2", 32'(out_valid), 32'd0);

    directed("prod_dom", 1, 0, 0, 130, 127, 128);
    directed("tie",      0, 0, 1, 127, 128, 128);
    directed("zero_prod", 1, 1, 0, 0, 200, 5);
    directed("sat_high", 0, 1, 1, 254, 254, 1);
    directed("underflow", 1, 0, 1, 1, 1, 255);

    // Backpressure: four back-to-back sets, three stalled cycles after first output
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      bit ordy;
      ordy = !(seen >= 1 && seen <= 3);
      step(i < 4, 1'(i), 1'(i >> 1), 1'(i + 1), 100 + i * 10, 120, 110 + i, ordy, ov);
      if (ov || seen > 0) seen++;
    end
    drain();

    // Random traffic with random backpressure
    for (int i = 0; i < 2000; i++) begin
      ea = (($urandom_range(0, 9) == 0) ? 0 : $urandom_range(0, 255));
      eb = (($urandom_range(0, 9) == 0) ? 0 : $urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) ec = ea + eb - BIAS + $urandom_range(0, 4) - 2;
      else ec = $urandom_range(0, 255);
      if (ec < 0) ec = 0;
      if (ec > 255) ec = 255;
      step($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 1'($urandom),
           ea, eb, ec, $urandom_range(0, 3) != 0, ov);
    end
    drain();

    // Reset while the pipeline is full discards both entries
    step(1, 1, 0, 0, 140, 130, 10, 0, ov);
    step(1, 0, 1, 0, 150, 130, 20, 0, ov);
    step(0, 0, 0, 0, 0, 0, 0, 0, ov);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_outputs", dut_out(), 32'd0);
    exp_q.delete();
    prev_stall = 0;
`ifdef MAF_SIGN_PREP_STATS_EN
    check("midrst_cnt", 32'(eff_sub_cnt), 32'd0);
    model_cnt = '0;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    directed("post_rst", 0, 0, 0, 127, 127, 127);

`ifdef MAF_SIGN_PREP_STATS_EN
    // Three effective subtractions and two additions from a cleared counter
    rst_n = 1'b0;
    #1;
    model_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1, i < 3, 0, 0, 130, 127, 128, 1, ov);
    drain();
    idle(1);
    check("stats_three", 32'(eff_sub_cnt), 32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_maf_sign_prep
